// File: rtl/n64_pkg.sv
// -----------------------------------------------------------------------------
// n64_pkg
// Shared definitions for the N64 controller poll scheduler:
//   - n64_state_t : scheduler FSM state encoding
//   - CMD_INFO / CMD_POLL : command bytes sent to the controller
//   - INFO_BITS : response length of the info/status command
//   - BTN_* / STICK_* : bit positions inside the 32-bit button word
//     (MSB = first bit received from the controller)
// -----------------------------------------------------------------------------
package n64_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_REQ = 3'd1,
      ST_SEND     = 3'd2,
      ST_RECV     = 3'd3,
      ST_LATCH    = 3'd4,
      ST_FAIL     = 3'd5
   } n64_state_t;

   localparam logic [7:0] CMD_INFO  = 8'h00;
   localparam logic [7:0] CMD_POLL  = 8'h01;
   localparam int         INFO_BITS = 24;

   // Button word layout, first received bit at bit 31.
   localparam int BTN_A       = 31;
   localparam int BTN_B       = 30;
   localparam int BTN_Z       = 29;
   localparam int BTN_START   = 28;
   localparam int BTN_DU      = 27;
   localparam int BTN_DD      = 26;
   localparam int BTN_DL      = 25;
   localparam int BTN_DR      = 24;
   localparam int BTN_RST     = 23;
   localparam int BTN_RSVD    = 22;
   localparam int BTN_L       = 21;
   localparam int BTN_R       = 20;
   localparam int BTN_CU      = 19;
   localparam int BTN_CD      = 18;
   localparam int BTN_CL      = 17;
   localparam int BTN_CR      = 16;
   localparam int STICK_X_LSB = 8;   // stick X occupies [15:8]
   localparam int STICK_Y_LSB = 0;   // stick Y occupies [7:0]

endpackage

// File: rtl/n64_poll_timer.sv
// -----------------------------------------------------------------------------
// n64_poll_timer
// Free-running poll period counter. Counts 0 .. POLL_PERIOD-1 and wraps,
// asserting tick_o for the single cycle in which the count is POLL_PERIOD-1.
//
// Ports:
//   clk     in   system clock
//   Reset   in   synchronous active-high reset (count -> 0)
//   tick_o  out  one-cycle pulse once per POLL_PERIOD cycles
// -----------------------------------------------------------------------------
module n64_poll_timer #(
   parameter int POLL_PERIOD = 833333
) (
   input  logic clk,
   input  logic Reset,
   output logic tick_o
);

   localparam int CNT_W = $clog2(POLL_PERIOD);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CNT_W'(POLL_PERIOD - 1));

   // NOTE: every next-state value gets a default before any branch so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick_o) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/n64_poll_scheduler.sv
// -----------------------------------------------------------------------------
// n64_poll_scheduler
// Polls an N64 controller at a fixed rate through the bit-level transceiver:
// sends the read-buttons command, turns the bus around, collects the response
// and publishes a latched button word. Missing/short responses are caught by
// an inter-bit timeout and consecutive failures are tracked.
//
// Optional build macro N64_INFO_PROBE_EN: after reset the first poll sends the
// info command (24-bit response) and keeps retrying it on every tick until it
// succeeds; Controller_Type then holds the first 16 response bits. Normal
// button polls start only after a successful probe.
//
// Ports:
//   clk              in   system clock
//   Reset            in   synchronous active-high reset
//   Poll_Enable      in   level; 0 parks the block in IDLE after current poll
//   Tx_Start         out  one-cycle pulse: transceiver sends Tx_Cmd
//   Tx_Cmd    [7:0]  out  command byte, valid with Tx_Start (0 otherwise)
//   Tx_Done          in   pulse: command and stop bit fully driven
//   Rx_Bit_Valid     in   pulse: one decoded response bit on Rx_Bit
//   Rx_Bit           in   decoded response bit
//   Enable_Send      out  transceiver drives the line
//   Enable_Recieve   out  transceiver samples the line
//   Buttons   [31:0] out  last good response, MSB = first bit received
//   Buttons_Valid    out  one-cycle pulse when Buttons updates
//   Poll_Error       out  one-cycle pulse on a failed poll
//   Controller_Lost  out  level; consecutive failures >= FAIL_LIMIT
//   Controller_Type [15:0] out (N64_INFO_PROBE_EN only) probe result
// -----------------------------------------------------------------------------
module n64_poll_scheduler
   import n64_pkg::*;
#(
   parameter int POLL_PERIOD = 833333,  // must exceed RX_TIMEOUT + 64
   parameter int RX_TIMEOUT  = 5000,
   parameter int RESP_BITS   = 32,
   parameter int FAIL_LIMIT  = 3
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Poll_Enable,
   output logic        Tx_Start,
   output logic [7:0]  Tx_Cmd,
   input  logic        Tx_Done,
   input  logic        Rx_Bit_Valid,
   input  logic        Rx_Bit,
   output logic        Enable_Send,
   output logic        Enable_Recieve,
   output logic [31:0] Buttons,
   output logic        Buttons_Valid,
   output logic        Poll_Error,
   output logic        Controller_Lost
`ifdef N64_INFO_PROBE_EN
   ,
   output logic [15:0] Controller_Type
`endif
);

   localparam int MAX_BITS = (RESP_BITS > INFO_BITS) ? RESP_BITS : INFO_BITS;
   localparam int BIT_W    = $clog2(MAX_BITS + 1);
   localparam int TO_W     = $clog2(RX_TIMEOUT + 1);
   localparam int FC_W     = $clog2(FAIL_LIMIT + 1);

   n64_state_t        state_q, state_d;
   logic [31:0]       shift_q, shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [31:0]       buttons_q, buttons_d;
   logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic              lost_q, lost_d;
   logic              tick;
   logic              probe_pending;
   logic [BIT_W-1:0]  bits_target;

`ifdef N64_INFO_PROBE_EN
   logic              probe_done_q, probe_done_d;
   logic [15:0]       ctype_q, ctype_d;

   // The info probe is outstanding until one has completed successfully.
   assign probe_pending   = ~probe_done_q;
   assign Controller_Type = ctype_q;
`else
   assign probe_pending   = 1'b0;
`endif

   assign bits_target     = probe_pending ? BIT_W'(INFO_BITS) : BIT_W'(RESP_BITS);
   assign Buttons         = buttons_q;
   assign Controller_Lost = lost_q;

   n64_poll_timer #(
      .POLL_PERIOD (POLL_PERIOD)
   ) u_timer (
      .clk    (clk),
      .Reset  (Reset),
      .tick_o (tick)
   );

   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      to_cnt_d       = to_cnt_q;
      buttons_d      = buttons_q;
      fail_cnt_d     = fail_cnt_q;
      lost_d         = lost_q;
`ifdef N64_INFO_PROBE_EN
      probe_done_d   = probe_done_q;
      ctype_d        = ctype_q;
`endif
      Tx_Start       = 1'b0;
      Tx_Cmd         = '0;
      Enable_Send    = 1'b0;
      Enable_Recieve = 1'b0;
      Buttons_Valid  = 1'b0;
      Poll_Error     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A tick seen in any other state is simply lost: no queuing.
            if (tick && Poll_Enable) begin
               state_d = ST_SEND_REQ;
            end
         end

         ST_SEND_REQ: begin
            Tx_Start    = 1'b1;
            Tx_Cmd      = probe_pending ? CMD_INFO : CMD_POLL;
            Enable_Send = 1'b1;
            state_d     = ST_SEND;
         end

         ST_SEND: begin
            Enable_Send = 1'b1;
            if (Tx_Done) begin
               state_d   = ST_RECV;
               bit_cnt_d = '0;
               shift_d   = '0;
               to_cnt_d  = '0;
            end
         end

         ST_RECV: begin
            Enable_Recieve = 1'b1;
            // A bit arriving in the expiry cycle takes priority over timeout.
            if (Rx_Bit_Valid) begin
               shift_d   = {shift_q[30:0], Rx_Bit};
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               to_cnt_d  = '0;
               if (bit_cnt_d == bits_target) begin
                  // Result registers load on entry to LATCH so they are
                  // already current while Buttons_Valid is high.
                  state_d    = ST_LATCH;
                  fail_cnt_d = '0;
                  lost_d     = 1'b0;
`ifdef N64_INFO_PROBE_EN
                  if (probe_pending) begin
                     ctype_d = shift_d[INFO_BITS-1 -: 16];
                  end else begin
                     buttons_d = shift_d;
                  end
`else
                  buttons_d = shift_d;
`endif
               end
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_d == TO_W'(RX_TIMEOUT)) begin
                  state_d = ST_FAIL;
                  if (fail_cnt_q != FC_W'(FAIL_LIMIT)) begin
                     fail_cnt_d = fail_cnt_q + FC_W'(1);
                  end
                  lost_d = (fail_cnt_d == FC_W'(FAIL_LIMIT));
               end
            end
         end

         ST_LATCH: begin
            // A successful probe is reported via Controller_Type only.
            Buttons_Valid = ~probe_pending;
`ifdef N64_INFO_PROBE_EN
            probe_done_d  = 1'b1;
`endif
            state_d       = ST_IDLE;
         end

         ST_FAIL: begin
            Poll_Error = 1'b1;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         to_cnt_q     <= '0;
         buttons_q    <= '0;
         fail_cnt_q   <= '0;
         lost_q       <= 1'b0;
`ifdef N64_INFO_PROBE_EN
         probe_done_q <= 1'b0;
         ctype_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         to_cnt_q     <= to_cnt_d;
         buttons_q    <= buttons_d;
         fail_cnt_q   <= fail_cnt_d;
         lost_q       <= lost_d;
`ifdef N64_INFO_PROBE_EN
         probe_done_q <= probe_done_d;
         ctype_q      <= ctype_d;
`endif
      end
   end

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_n64_poll_scheduler
// Directed + randomized bench for n64_poll_scheduler with a short poll period.
// The reference model works at the transaction level: poll start times are
// derived from the tick arithmetic (next multiple of POLL_PERIOD after the
// block is idle and enabled), results from the bits actually driven, and the
// failure tracker as a saturating count of consecutive failed polls.
// Honours N64_INFO_PROBE_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_n64_poll_scheduler;
   import n64_pkg::*;

   localparam int P     = 200;
   localparam int TO    = 50;
   localparam int NBITS = 32;
   localparam int FLIM  = 3;

   logic        clk = 1'b0;
   logic        Reset;
   logic        Poll_Enable;
   logic        Tx_Start;
   logic [7:0]  Tx_Cmd;
   logic        Tx_Done;
   logic        Rx_Bit_Valid;
   logic        Rx_Bit;
   logic        Enable_Send;
   logic        Enable_Recieve;
   logic [31:0] Buttons;
   logic        Buttons_Valid;
   logic        Poll_Error;
   logic        Controller_Lost;
`ifdef N64_INFO_PROBE_EN
   logic [15:0] Controller_Type;
   logic [15:0] exp_ctype;
`endif

   int          total = 0;
   int          bad   = 0;
   int          since_rst;     // clock edges since reset was released
   int          last_end;      // since_rst at which the last poll ended
   int          en_since;      // since_rst at which Poll_Enable went to 1
   int          fails;         // model: consecutive failed polls (saturating)
   logic [31:0] exp_buttons;
   bit          probe_done;

   n64_poll_scheduler #(
      .POLL_PERIOD (P),
      .RX_TIMEOUT  (TO),
      .RESP_BITS   (NBITS),
      .FAIL_LIMIT  (FLIM)
   ) dut (
      .clk             (clk),
      .Reset           (Reset),
      .Poll_Enable     (Poll_Enable),
      .Tx_Start        (Tx_Start),
      .Tx_Cmd          (Tx_Cmd),
      .Tx_Done         (Tx_Done),
      .Rx_Bit_Valid    (Rx_Bit_Valid),
      .Rx_Bit          (Rx_Bit),
      .Enable_Send     (Enable_Send),
      .Enable_Recieve  (Enable_Recieve),
      .Buttons         (Buttons),
      .Buttons_Valid   (Buttons_Valid),
      .Poll_Error      (Poll_Error),
      .Controller_Lost (Controller_Lost)
`ifdef N64_INFO_PROBE_EN
      ,
      .Controller_Type (Controller_Type)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      since_rst <= Reset ? 0 : since_rst + 1;
   end

   task automatic report(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Continuous properties: bus direction exclusivity; Tx_Start only after a tick.
   always @(negedge clk) begin
      total++;
      assert (!(Enable_Send && Enable_Recieve))
         else report("dir_exclusive", {30'd0, Enable_Send, Enable_Recieve}, 32'd0);
      if (Tx_Start) begin
         total++;
         assert (since_rst > 0 && since_rst % P == 0)
            else report("start_on_tick", since_rst, (since_rst / P + 1) * P);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      last_end    = -1;
      en_since    = 0;
      fails       = 0;
      exp_buttons = '0;
`ifdef N64_INFO_PROBE_EN
      probe_done  = 1'b0;
      exp_ctype   = '0;
`else
      probe_done  = 1'b1;
`endif
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      assert ({Tx_Start, Tx_Cmd, Enable_Send, Enable_Recieve, Buttons_Valid,
               Poll_Error, Controller_Lost} === 14'd0)
         else report({tag, "_ctl"}, {18'd0, Tx_Start, Tx_Cmd, Enable_Send, Enable_Recieve,
                     Buttons_Valid, Poll_Error, Controller_Lost}, 32'd0);
      total++;
      assert (Buttons === 32'd0) else report({tag, "_buttons"}, Buttons, 32'd0);
`ifdef N64_INFO_PROBE_EN
      total++;
      assert (Controller_Type === 16'd0)
         else report({tag, "_ctype"}, {16'd0, Controller_Type}, 32'd0);
`endif
   endtask

   // Waits for Tx_Start and checks it lands on the first tick at which the
   // block is both idle and enabled.
   task automatic wait_start(input string tag, output bit ok);
      int lower;
      int exp_k;
      ok    = 1'b0;
      lower = (last_end + 1 > en_since) ? last_end + 1 : en_since;
      exp_k = (lower / P + 1) * P;
      for (int i = 0; i < 3 * P; i++) begin
         step();
         if (Tx_Start) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      assert (ok) else report({tag, "_start_seen"}, 32'd0, 32'd1);
      if (ok) begin
         total++;
         assert (since_rst === exp_k) else report({tag, "_start_cycle"}, since_rst, exp_k);
      end
   endtask

   task automatic do_reset_mid(input string tag);
      Reset = 1'b1;
      step();
      check_all_zero({tag, "_rst"});
      step();
      Reset = 1'b0;
      model_reset();
   endtask

   // One poll transaction. n_sent < response length models a short response;
   // long_gap_at puts an RX_TIMEOUT-1 idle gap (the boundary) before that bit.
   task automatic do_poll(input string tag, input logic [31:0] word, input int n_sent,
                          input int gap_max, input int long_gap_at, input bit spurious,
                          input int extras, input bit drop_en, input int reset_at);
      bit         ok;
      bit         is_probe;
      logic [7:0] exp_cmd;
      int         resp_len;
      int         cnt;
      int         g;
      is_probe = !probe_done;
      exp_cmd  = is_probe ? CMD_INFO : CMD_POLL;
      resp_len = is_probe ? INFO_BITS : NBITS;

      wait_start(tag, ok);
      if (!ok) return;
      total++;
      assert (Tx_Cmd === exp_cmd) else report({tag, "_cmd"}, {24'd0, Tx_Cmd}, {24'd0, exp_cmd});
      total++;
      assert ({Enable_Send, Enable_Recieve} === 2'b10)
         else report({tag, "_dir_send"}, {30'd0, Enable_Send, Enable_Recieve}, 32'd2);

      if (spurious) begin
         // Tx_Done during SEND_REQ and bits during SEND/SEND_REQ must be ignored.
         Tx_Done      = 1'b1;
         Rx_Bit_Valid = 1'b1;
         Rx_Bit       = 1'b1;
         step();
         Tx_Done = 1'b0;
         step();
         Rx_Bit_Valid = 1'b0;
         total++;
         assert (Enable_Send === 1'b1) else report({tag, "_send_hold"}, Enable_Send, 32'd1);
      end else begin
         step();
         repeat ($urandom_range(0, 3)) step();
      end

      Tx_Done = 1'b1;
      step();
      Tx_Done = 1'b0;
      if (drop_en) Poll_Enable = 1'b0;
      total++;
      assert ({Enable_Send, Enable_Recieve} === 2'b01)
         else report({tag, "_dir_recv"}, {30'd0, Enable_Send, Enable_Recieve}, 32'd1);

      for (int i = 0; i < n_sent; i++) begin
         g = (i == long_gap_at) ? TO - 1 : int'($urandom_range(0, gap_max));
         repeat (g) step();
         Rx_Bit_Valid = 1'b1;
         Rx_Bit       = word[resp_len-1-i];
         Tx_Done      = spurious && (i == 3);
         step();
         Rx_Bit_Valid = 1'b0;
         Tx_Done      = 1'b0;
         if (i + 1 == reset_at) begin
            do_reset_mid(tag);
            return;
         end
      end

      if (n_sent == resp_len) begin
         fails = 0;
         if (is_probe) begin
            probe_done = 1'b1;
`ifdef N64_INFO_PROBE_EN
            exp_ctype = word[23:8];
            total++;
            assert (Controller_Type === exp_ctype)
               else report({tag, "_ctype"}, {16'd0, Controller_Type}, {16'd0, exp_ctype});
`endif
         end else begin
            exp_buttons = word;
         end
         total++;
         assert (Buttons_Valid === !is_probe)
            else report({tag, "_valid_pulse"}, Buttons_Valid, {31'd0, !is_probe});
         total++;
         assert (Buttons === exp_buttons) else report({tag, "_buttons"}, Buttons, exp_buttons);
         total++;
         assert (Controller_Lost === 1'b0) else report({tag, "_lost_clr"}, Controller_Lost, 32'd0);
         last_end = since_rst;
         for (int e = 0; e < extras; e++) begin
            Rx_Bit_Valid = 1'b1;
            Rx_Bit       = 1'($urandom);
            step();
            Rx_Bit_Valid = 1'b0;
            total++;
            assert ({Buttons_Valid, Buttons} === {1'b0, exp_buttons})
               else report({tag, "_extra_bits"}, Buttons, exp_buttons);
         end
      end else begin
         cnt = 0;
         while (!Poll_Error && cnt < 3 * TO) begin
            step();
            cnt++;
         end
         total++;
         assert (cnt === TO) else report({tag, "_timeout_lat"}, cnt, TO);
         fails = (fails + 1 > FLIM) ? FLIM : fails + 1;
         total++;
         assert (Controller_Lost === (fails >= FLIM))
            else report({tag, "_lost"}, Controller_Lost, {31'd0, fails >= FLIM});
         total++;
         assert ({Buttons_Valid, Buttons} === {1'b0, exp_buttons})
            else report({tag, "_buttons_kept"}, Buttons, exp_buttons);
         last_end = since_rst;
      end
   endtask

   initial begin
      bit          seen;
      bit          fail_poll;
      int          n;
      int          lg;
      logic [31:0] w;

      Reset        = 1'b1;
      Poll_Enable  = 1'b0;
      Tx_Done      = 1'b0;
      Rx_Bit_Valid = 1'b0;
      Rx_Bit       = 1'b0;
      model_reset();
      repeat (3) step();
      check_all_zero("reset");
      Reset       = 1'b0;
      Poll_Enable = 1'b1;

`ifdef N64_INFO_PROBE_EN
      do_poll("probe_to", 32'd0, 5, 3, -1, 1'b0, 0, 1'b0, -1);
      do_poll("probe_retry", 32'h0005_0002, INFO_BITS, 2, -1, 1'b0, 2, 1'b0, -1);
`endif

      // Basic poll, back-to-back bits.
      do_poll("basic", 32'h8000_7F81, NBITS, 0, -1, 1'b0, 0, 1'b0, -1);
      total++;
      assert ({Buttons[BTN_A], Buttons[BTN_B], Buttons[BTN_Z], Buttons[BTN_START],
               Buttons[BTN_DU], Buttons[BTN_DD], Buttons[BTN_DL], Buttons[BTN_DR],
               Buttons[BTN_RST], Buttons[BTN_RSVD], Buttons[BTN_L], Buttons[BTN_R],
               Buttons[BTN_CU], Buttons[BTN_CD], Buttons[BTN_CL], Buttons[BTN_CR],
               Buttons[STICK_X_LSB+:8], Buttons[STICK_Y_LSB+:8]} === 32'h8000_7F81)
         else report("field_map", Buttons, 32'h8000_7F81);
      step();
      total++;
      assert (Buttons_Valid === 1'b0) else report("valid_one_cycle", Buttons_Valid, 32'd0);

      // Short responses: Controller_Lost on the third, saturation on the fourth.
      for (int k = 0; k < 4; k++) begin
         do_poll("timeout", $urandom, 10, 3, -1, 1'b0, 0, 1'b0, -1);
      end

      // Good poll recovers; spurious inputs, boundary gap, extra trailing bits.
      do_poll("spurious", 32'hA5C3_1E69, NBITS, 4, 7, 1'b1, 5, 1'b0, -1);

      // Randomized polls.
      for (int k = 0; k < 8; k++) begin
         w         = $urandom;
         fail_poll = ($urandom_range(0, 3) == 0);
         n         = fail_poll ? int'($urandom_range(0, NBITS - 1)) : NBITS;
         lg        = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         do_poll("random", w, n, int'($urandom_range(0, 6)), lg, 1'($urandom),
                 int'($urandom_range(0, 3)), 1'b0, -1);
      end

      // Poll_Enable dropped mid-poll: poll completes, then no new poll.
      do_poll("drop_en", $urandom, NBITS, 2, -1, 1'b0, 0, 1'b1, -1);
      seen = 1'b0;
      repeat (2 * P) begin
         step();
         if (Tx_Start) seen = 1'b1;
      end
      total++;
      assert (seen === 1'b0) else report("disabled_no_start", seen, 32'd0);
      Poll_Enable = 1'b1;
      en_since    = since_rst;
      do_poll("reenable", $urandom, NBITS, 2, -1, 1'b0, 0, 1'b0, -1);

      // Reset in the middle of a response, then a fresh poll.
      do_poll("rst_mid", $urandom, NBITS, 2, -1, 1'b0, 0, 1'b0, 16);
`ifdef N64_INFO_PROBE_EN
      do_poll("probe_again", 32'h00AB_CD01, INFO_BITS, 2, -1, 1'b0, 0, 1'b0, -1);
`endif
      do_poll("after_rst", $urandom, NBITS, 2, -1, 1'b0, 0, 1'b0, -1);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
- Sequences the N64 bit-level send/receive transceiver to poll the controller at a fixed rate.
- Per poll: issues the 0x01 "read buttons" command, turns the single-wire bus around, collects the 32-bit response, and publishes a latched button word.
- Detects missing or short responses with a timeout and tracks consecutive failures.
- Sits between the transceiver state machine and the game/user logic.

Parameters:
- POLL_PERIOD, 833333, clock cycles between poll starts (60 Hz at 50 MHz); must be > RX_TIMEOUT + 64.
- RX_TIMEOUT, 5000, max cycles in RECV without a new bit before a poll is abandoned.
- RESP_BITS, 32, response length for the 0x01 command.
- FAIL_LIMIT, 3, consecutive failed polls before Controller_Lost asserts.

Ports:
- clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Poll_Enable  input  1  level; 0 holds the block in IDLE after the current poll finishes.
- Tx_Start  output  1  one-cycle pulse to the transceiver: send Tx_Cmd.
- Tx_Cmd  output  8  command byte, valid while Tx_Start=1.
- Tx_Done  input  1  one-cycle pulse: command plus stop bit fully driven.
- Rx_Bit_Valid  input  1  one-cycle pulse: one decoded response bit available.
- Rx_Bit  input  1  decoded bit, valid with Rx_Bit_Valid.
- Enable_Send  output  1  bus direction: transceiver drives the line.
- Enable_Recieve  output  1  bus direction: transceiver samples the line.
- Buttons  output  32  last good response, MSB = first bit received.
- Buttons_Valid  output  1  one-cycle pulse when Buttons updates.
- Poll_Error  output  1  one-cycle pulse on a failed poll.
- Controller_Lost  output  1  level; consecutive failures >= FAIL_LIMIT.

Behaviour:
- Reset values: all outputs 0, Buttons = 0, state IDLE, period counter 0, fail count 0.
- Enable_Send and Enable_Recieve are never both 1 (mutually exclusive by construction).
- The period counter free-runs from reset. It wraps at POLL_PERIOD-1, producing a tick. The counter runs in every state.
- States:
  - IDLE: on tick with Poll_Enable=1 -> SEND_REQ.
  - SEND_REQ (1 cycle): Tx_Start=1, Tx_Cmd=8'h01, Enable_Send=1 -> SEND.
  - SEND: Enable_Send=1, wait for Tx_Done. On Tx_Done -> RECV with the following cleared: bit counter, shift register, timeout counter.
  - RECV: Enable_Recieve=1.
    - On Rx_Bit_Valid: shift in Rx_Bit (left shift, LSB fill), increment bit counter, clear timeout counter.
    - When the bit counter reaches RESP_BITS -> LATCH.
    - When the timeout counter reaches RX_TIMEOUT -> FAIL.
  - LATCH (1 cycle): Buttons <= shift register; Buttons_Valid=1; fail count cleared; Controller_Lost cleared -> IDLE.
  - FAIL (1 cycle): Poll_Error=1; fail count increments (saturating at FAIL_LIMIT); Controller_Lost=1 when the count reaches FAIL_LIMIT; Buttons retained -> IDLE.
- Latency: Buttons_Valid occurs exactly 1 cycle after the Rx_Bit_Valid that carries bit RESP_BITS.
- Edge cases:
  - Tick while not in IDLE: ignored; no queuing. The next poll waits for the next tick.
  - Rx_Bit_Valid in IDLE/SEND/SEND_REQ: ignored.
  - Extra bits after RESP_BITS: ignored, because the block is already in LATCH/IDLE.
  - Tx_Done outside SEND: ignored.
  - Rx_Bit_Valid and timeout expiry in the same cycle: the bit wins and the timeout counter is cleared.
  - Poll_Enable deasserted mid-poll: the current poll completes normally.
  - Reset mid-poll: immediate return to reset values next cycle; Buttons cleared.

Optional Feature:
- Macro N64_INFO_PROBE_EN.
- Defined:
  - After reset, the first poll sends 8'h00 (info/status) instead of 8'h01 and expects 24 bits.
  - Adds output Controller_Type [15:0] (first 16 response bits), reset 0, updated on a successful probe.
  - On probe failure, the probe is retried on every tick until it succeeds. Only after success do normal 0x01 polls begin.
  - Buttons_Valid does not pulse for the probe.
  - FAIL counting applies to the probe.
- Undefined: no Controller_Type port; the first poll is 0x01.

Decomposition:
- Package n64_pkg holds:
  - state enum typedef;
  - constants CMD_INFO=8'h00, CMD_POLL=8'h01, INFO_BITS=24;
  - the button-word bit positions (A, B, Z, Start, D-pad, L, R, C-buttons, stick X[7:0], stick Y[7:0]).
- Sub-module n64_poll_timer: period counter plus tick, parameterized by POLL_PERIOD. It is natural to split out; the rest stays in one FSM.

Test Plan:
- Basic poll: POLL_PERIOD=200, RX_TIMEOUT=50. Tick -> Tx_Start with Tx_Cmd=01. Then Tx_Done, then 32 bits of 32'h8000_7F81 -> Buttons=32'h80007F81 and one Buttons_Valid pulse 1 cycle after the last bit.
- Timeout: after Tx_Done, send 10 bits then stop -> Poll_Error pulse 50 cycles after the 10th bit; Buttons unchanged. Three consecutive such polls -> Controller_Lost=1. Then one good poll -> Controller_Lost=0.
- Direction exclusivity: over random polls, Enable_Send and Enable_Recieve are never both 1. Enable_Send=1 only in SEND_REQ/SEND; no Tx_Start except on a tick from IDLE.
- Spurious inputs: Rx_Bit_Valid pulses during SEND and 5 extra bits after the 32nd -> ignored; Buttons equals only the 32 in-window bits.
- Reset mid-RECV after 16 bits -> next cycle all outputs 0, state IDLE. The next tick starts a fresh poll.
- With N64_INFO_PROBE_EN:
  - First command = 00 with response 24'h050002 -> Controller_Type=16'h0500 and no Buttons_Valid. Next tick sends 01.
  - Probe timeout -> the probe repeats on the next tick.
